// File: rtl/osnt_sume_bram_pkg.sv
// Shared definitions for the OSNT SUME dual-port block RAM: FSM encoding,
// collision priority selectors and geometry helpers.
package osnt_sume_bram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } bram_state_e;

  localparam int PRIO_PORT_A = 0;
  localparam int PRIO_PORT_B = 1;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic int calc_word_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int calc_depth(input int addr_width, input int data_width);
    return 1 << (addr_width - calc_word_lsb(data_width));
  endfunction

endpackage

// File: rtl/osnt_sume_bram_rdpipe.sv
// Per-port read pipeline: captures the addressed word on an accepted read and
// optionally adds a second output register stage.
module osnt_sume_bram_rdpipe
  import osnt_sume_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] rd_word_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;

  // First stage: array output latch, holds its value between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      if (rd_en_i) begin
        s1_data_q <= rd_word_i;
      end else begin
        s1_data_q <= s1_data_q;
      end
      s1_valid_q <= rd_en_i;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_valid_q;

      // Second stage: retimes the array output for an extra cycle of latency.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
        end else begin
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end else begin
            s2_data_q <= s2_data_q;
          end
          s2_valid_q <= s1_valid_q;
        end
      end

      assign rd_data_o  = s2_data_q;
      assign rd_valid_o = s2_valid_q;
    end else begin : g_no_out_reg
      assign rd_data_o  = s1_data_q;
      assign rd_valid_o = s1_valid_q;
    end
  endgenerate

endmodule

// File: rtl/osnt_sume_bram_dp.sv
// Single-clock true-dual-port byte-addressed RAM with clear engine,
// read-valid strobes and a saturating write-collision counter.
module osnt_sume_bram_dp
  import osnt_sume_bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 512,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int COLLISION_PRIO = 0
) (
  input  logic                    axis_aclk,
  input  logic                    axis_resetn,
  input  logic [ADDR_WIDTH-1:0]   bram_addr_a,
  input  logic                    bram_en_a,
  input  logic [DATA_WIDTH/8-1:0] bram_we_a,
  input  logic [DATA_WIDTH-1:0]   bram_wrdata_a,
  output logic [DATA_WIDTH-1:0]   bram_rddata_a,
  output logic                    bram_rdvalid_a,
  input  logic [ADDR_WIDTH-1:0]   bram_addr_b,
  input  logic                    bram_en_b,
  input  logic [DATA_WIDTH/8-1:0] bram_we_b,
  input  logic [DATA_WIDTH-1:0]   bram_wrdata_b,
  output logic [DATA_WIDTH-1:0]   bram_rddata_b,
  output logic                    bram_rdvalid_b,
  input  logic                    clear_req,
  output logic                    init_done,
  output logic [31:0]             collision_cnt
);

  localparam int WORD_LSB = calc_word_lsb(DATA_WIDTH);
  localparam int DEPTH    = calc_depth(ADDR_WIDTH, DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - WORD_LSB;
  localparam int NBYTES   = DATA_WIDTH / 8;

  localparam bram_state_e      RST_STATE     = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic             RST_INIT_DONE = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
  localparam logic [IDX_W-1:0] CLR_LAST      = IDX_W'(DEPTH - 1);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  bram_state_e       state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              init_done_q, init_done_d;
  logic [31:0]       collision_cnt_q, collision_cnt_d;
  logic              clr_start_s;

  logic [IDX_W-1:0]      idx_a_s, idx_b_s;
  logic                  wr_a_s, wr_b_s, rd_a_s, rd_b_s;
  logic                  collision_s;
  logic [DATA_WIDTH-1:0] rd_word_a_s, rd_word_b_s;
  logic                  unused_addr_lsb_s;

  assign idx_a_s = bram_addr_a[ADDR_WIDTH-1:WORD_LSB];
  assign idx_b_s = bram_addr_b[ADDR_WIDTH-1:WORD_LSB];
  assign unused_addr_lsb_s = ^{bram_addr_a[WORD_LSB-1:0], bram_addr_b[WORD_LSB-1:0]};

  // Accesses are only honoured once the array is usable.
  assign wr_a_s = bram_en_a && init_done_q && (|bram_we_a);
  assign wr_b_s = bram_en_b && init_done_q && (|bram_we_b);
  assign rd_a_s = bram_en_a && init_done_q && !(|bram_we_a);
  assign rd_b_s = bram_en_b && init_done_q && !(|bram_we_b);

  assign collision_s = wr_a_s && wr_b_s && (idx_a_s == idx_b_s) && (|(bram_we_a & bram_we_b));

  // Clear-engine next state; init_done tracks the IDLE state.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    clr_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d     = ST_CLEAR;
          clr_ptr_d   = '0;
          init_done_d = 1'b0;
          clr_start_s = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_ptr_q == CLR_LAST) begin
          state_d     = ST_IDLE;
          clr_ptr_d   = '0;
          init_done_d = 1'b1;
        end else begin
          clr_ptr_d   = clr_ptr_q + IDX_W'(1);
          init_done_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        clr_ptr_d   = '0;
        init_done_d = 1'b1;
      end
    endcase
  end

  // Collision counter: saturates, zeroed only by an accepted clear request.
  always_comb begin
    collision_cnt_d = collision_cnt_q;
    if (clr_start_s) begin
      collision_cnt_d = '0;
    end else if (collision_s && (collision_cnt_q != CNT_MAX)) begin
      collision_cnt_d = collision_cnt_q + 32'd1;
    end else begin
      collision_cnt_d = collision_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q         <= RST_STATE;
      clr_ptr_q       <= '0;
      init_done_q     <= RST_INIT_DONE;
      collision_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      clr_ptr_q       <= clr_ptr_d;
      init_done_q     <= init_done_d;
      collision_cnt_q <= collision_cnt_d;
    end
  end

  // Array writes: the losing port is written first so the winner's byte lands last.
  always_ff @(posedge axis_aclk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (COLLISION_PRIO == PRIO_PORT_B) begin
          if (wr_a_s && bram_we_a[i]) mem_q[idx_a_s][8*i +: 8] <= bram_wrdata_a[8*i +: 8];
          if (wr_b_s && bram_we_b[i]) mem_q[idx_b_s][8*i +: 8] <= bram_wrdata_b[8*i +: 8];
        end else begin
          if (wr_b_s && bram_we_b[i]) mem_q[idx_b_s][8*i +: 8] <= bram_wrdata_b[8*i +: 8];
          if (wr_a_s && bram_we_a[i]) mem_q[idx_a_s][8*i +: 8] <= bram_wrdata_a[8*i +: 8];
        end
      end
    end
  end

  assign rd_word_a_s = mem_q[idx_a_s];
  assign rd_word_b_s = mem_q[idx_b_s];

  osnt_sume_bram_rdpipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rdpipe_a (
    .clk_i      (axis_aclk),
    .rst_n_i    (axis_resetn),
    .rd_en_i    (rd_a_s),
    .rd_word_i  (rd_word_a_s),
    .rd_data_o  (bram_rddata_a),
    .rd_valid_o (bram_rdvalid_a)
  );

  osnt_sume_bram_rdpipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rdpipe_b (
    .clk_i      (axis_aclk),
    .rst_n_i    (axis_resetn),
    .rd_en_i    (rd_b_s),
    .rd_word_i  (rd_word_b_s),
    .rd_data_o  (bram_rddata_b),
    .rd_valid_o (bram_rdvalid_b)
  );

  assign init_done     = init_done_q;
  assign collision_cnt = collision_cnt_q;

endmodule

// File: tb/tb_osnt_sume_bram_dp.sv
// Directed bench: two instances (OUT_REG=0/PRIO=A and OUT_REG=1/PRIO=B) share
// stimulus; expected values are hand-computed constants.
module tb_osnt_sume_bram_dp;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [AW-1:0] addr_a, addr_b;
  logic          en_a, en_b;
  logic [BW-1:0] we_a, we_b;
  logic [DW-1:0] wd_a, wd_b;
  logic          clear_req;

  logic [DW-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic          rv_a0, rv_b0, rv_a1, rv_b1;
  logic          done0, done1;
  logic [31:0]   cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  osnt_sume_bram_dp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .CLEAR_ON_RESET(1), .COLLISION_PRIO(0)
  ) u_dut0 (
    .axis_aclk(clk), .axis_resetn(resetn),
    .bram_addr_a(addr_a), .bram_en_a(en_a), .bram_we_a(we_a), .bram_wrdata_a(wd_a),
    .bram_rddata_a(rd_a0), .bram_rdvalid_a(rv_a0),
    .bram_addr_b(addr_b), .bram_en_b(en_b), .bram_we_b(we_b), .bram_wrdata_b(wd_b),
    .bram_rddata_b(rd_b0), .bram_rdvalid_b(rv_b0),
    .clear_req(clear_req), .init_done(done0), .collision_cnt(cnt0)
  );

  osnt_sume_bram_dp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .CLEAR_ON_RESET(1), .COLLISION_PRIO(1)
  ) u_dut1 (
    .axis_aclk(clk), .axis_resetn(resetn),
    .bram_addr_a(addr_a), .bram_en_a(en_a), .bram_we_a(we_a), .bram_wrdata_a(wd_a),
    .bram_rddata_a(rd_a1), .bram_rdvalid_a(rv_a1),
    .bram_addr_b(addr_b), .bram_en_b(en_b), .bram_we_b(we_b), .bram_wrdata_b(wd_b),
    .bram_rddata_b(rd_b1), .bram_rdvalid_b(rv_b1),
    .clear_req(clear_req), .init_done(done1), .collision_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    en_a = 1'b0; en_b = 1'b0;
    we_a = '0;   we_b = '0;
  endtask

  task automatic write_a(input logic [AW-1:0] addr, input logic [BW-1:0] we, input logic [DW-1:0] d);
    addr_a = addr; en_a = 1'b1; we_a = we; wd_a = d;
    step();
    idle_ports();
  endtask

  // Single read; dut0 answers after one edge, dut1 after two.
  task automatic rd_check(input logic port_b, input logic [AW-1:0] addr,
                          input logic [DW-1:0] exp0, input logic [DW-1:0] exp1, input string tag);
    if (port_b) begin addr_b = addr; en_b = 1'b1; we_b = '0; end
    else        begin addr_a = addr; en_a = 1'b1; we_a = '0; end
    step();
    chk({tag, "_valid_lat1"}, port_b ? rv_b0 : rv_a0, 1);
    chk({tag, "_data_lat1"},  port_b ? rd_b0 : rd_a0, exp0);
    chk({tag, "_valid_early"}, port_b ? rv_b1 : rv_a1, 0);
    idle_ports();
    step();
    chk({tag, "_valid_lat2"}, port_b ? rv_b1 : rv_a1, 1);
    chk({tag, "_data_lat2"},  port_b ? rd_b1 : rd_a1, exp1);
    chk({tag, "_valid_drop"}, port_b ? rv_b0 : rv_a0, 0);
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    do begin
      step();
      cyc++;
    end while (!done0 && cyc < 300);
    chk({tag, "_init_cycles"}, cyc, 128);
    chk({tag, "_init_done1"}, done1, 1);
  endtask

  // Back-to-back reads of every word on port A; all must be zero.
  task automatic read_all_zero(input string tag);
    int v0 = 0, v1 = 0;
    logic [DW-1:0] or0 = '0, or1 = '0;
    for (int i = 0; i < 130; i++) begin
      if (i < 128) begin
        addr_a = AW'(i << 3); en_a = 1'b1; we_a = '0;
      end else begin
        idle_ports();
      end
      step();
      if (rv_a0) begin v0++; or0 |= rd_a0; end
      if (rv_a1) begin v1++; or1 |= rd_a1; end
    end
    chk({tag, "_nvalid0"}, v0, 128);
    chk({tag, "_nvalid1"}, v1, 128);
    chk({tag, "_or_data0"}, or0, 0);
    chk({tag, "_or_data1"}, or1, 0);
  endtask

  initial begin
    resetn = 1'b0; clear_req = 1'b0;
    addr_a = '0; addr_b = '0; wd_a = '0; wd_b = '0;
    idle_ports();
    repeat (3) step();
    chk("rst_rddata_a", rd_a0, 0);
    chk("rst_rdvalid_b", rv_b1, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_init_done", done0, 0);

    resetn = 1'b1;
    wait_init("boot");
    read_all_zero("boot");

    write_a(10'h040, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    rd_check(1'b1, 10'h047, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, "wr_a_rd_b");

    // Collision on word 3 over a known background.
    write_a(10'h018, 8'hFF, 64'hAAAAAAAA_AAAAAAAA);
    addr_a = 10'h018; en_a = 1'b1; we_a = 8'h0F; wd_a = 64'h11111111_11111111;
    addr_b = 10'h01C; en_b = 1'b1; we_b = 8'h3C; wd_b = 64'h22222222_22222222;
    step();
    idle_ports();
    chk("coll_cnt0", cnt0, 1);
    chk("coll_cnt1", cnt1, 1);
    rd_check(1'b0, 10'h018, 64'hAAAA2222_11111111, 64'hAAAA2222_22221111, "coll");

    // Read-first on same word from the other port; not a collision.
    addr_a = 10'h028; en_a = 1'b1; we_a = 8'hFF; wd_a = 64'h01234567_89ABCDEF;
    addr_b = 10'h028; en_b = 1'b1; we_b = '0;
    step();
    chk("rdw_old_valid0", rv_b0, 1);
    chk("rdw_old_data0", rd_b0, 0);
    en_a = 1'b0; we_a = '0;
    step();
    chk("rdw_new_data0", rd_b0, 64'h01234567_89ABCDEF);
    chk("rdw_old_data1", rd_b1, 0);
    idle_ports();
    step();
    chk("rdw_new_data1", rd_b1, 64'h01234567_89ABCDEF);
    chk("rdw_no_coll", cnt0, 1);

    // Saturation: preload the counters just below the limit.
    force u_dut0.collision_cnt_q = 32'hFFFF_FFFE;
    force u_dut1.collision_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut0.collision_cnt_q;
    release u_dut1.collision_cnt_q;
    for (int k = 0; k < 2; k++) begin
      addr_a = 10'h050; en_a = 1'b1; we_a = 8'h01; wd_a = 64'h5;
      addr_b = 10'h050; en_b = 1'b1; we_b = 8'h01; wd_b = 64'h6;
      step();
      idle_ports();
      chk("sat_cnt0", cnt0, 32'hFFFF_FFFF);
    end
    chk("sat_cnt1", cnt1, 32'hFFFF_FFFF);

    write_a(10'h320, 8'hFF, 64'h12345678_9ABCDEF0);

    // Clear request, then reset in the middle of the clear.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clr_cnt_zero", cnt0, 0);
    chk("clr_init_low", done0, 0);
    repeat (39) step();
    resetn = 1'b0;
    repeat (3) step();
    chk("midclr_rst_init", done0, 0);
    chk("midclr_rst_valid", rv_a0, 0);
    resetn = 1'b1;
    wait_init("reclear");

    // Clear request right after init_done rises.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("b2b_init_low", done0, 0);
    wait_init("b2b");
    read_all_zero("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
